// File: rtl/led_pattern_gen.sv
// N-channel LED pattern generator: a prescaler tick drives the off, blink, chaser and PWM-dim patterns.
// Mode and duty are latched by a single-cycle load strobe, which also restarts every pattern counter.
module led_pattern_gen #(
  parameter int N_CH     = 4,
  parameter int PRESCALE = 25000000
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  input  logic            iLOAD,
  input  logic [1:0]      iMODE,
  input  logic [7:0]      iDUTY,
  input  logic            iDIR,
  output logic [N_CH-1:0] oLED,
  output logic            oTICK
);

  localparam int PW   = $clog2(PRESCALE);
  localparam int POSW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_BLINK = 2'b01,
    MODE_CHASE = 2'b10,
    MODE_PWM   = 2'b11
  } mode_e;

  mode_e           mode_q, mode_d;
  logic [7:0]      duty_q, duty_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            blink_q, blink_d;
  logic [POSW-1:0] pos_q, pos_d;
  logic [7:0]      pwm_q, pwm_d;
  logic            tick;

  assign tick  = (presc_q == PW'(PRESCALE - 1));
  assign oTICK = tick;

  // A load restarts everything and swallows a coincident tick; otherwise only the active pattern moves.
  always_comb begin
    mode_d  = mode_q;
    duty_d  = duty_q;
    presc_d = presc_q;
    blink_d = blink_q;
    pos_d   = pos_q;
    pwm_d   = pwm_q;
    if (iLOAD) begin
      mode_d  = mode_e'(iMODE);
      duty_d  = iDUTY;
      presc_d = '0;
      blink_d = 1'b0;
      pos_d   = '0;
      pwm_d   = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (mode_q == MODE_PWM) begin
        pwm_d = pwm_q + 8'd1;
      end
      if (tick) begin
        case (mode_q)
          MODE_BLINK: blink_d = ~blink_q;
          MODE_CHASE: begin
            if (iDIR) begin
              pos_d = (pos_q == '0) ? POSW'(N_CH - 1) : pos_q - POSW'(1);
            end else begin
              pos_d = (pos_q == POSW'(N_CH - 1)) ? '0 : pos_q + POSW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      mode_q  <= MODE_OFF;
      duty_q  <= '0;
      presc_q <= '0;
      blink_q <= 1'b0;
      pos_q   <= '0;
      pwm_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      duty_q  <= duty_d;
      presc_q <= presc_d;
      blink_q <= blink_d;
      pos_q   <= pos_d;
      pwm_q   <= pwm_d;
    end
  end

  // LEDs decode from registered state only, so reset forces them dark without waiting for a clock.
  always_comb begin
    oLED = '0;
    case (mode_q)
      MODE_BLINK: oLED = {N_CH{blink_q}};
      MODE_CHASE: oLED = N_CH'(1) << pos_q;
      MODE_PWM:   oLED = {N_CH{pwm_q < duty_q}};
      default:    oLED = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: an elapsed-cycle model is compared every cycle,
// with directed scenarios pinning literal values and a randomized phase afterwards.
module tb_led_pattern_gen;

  localparam int P = 4;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         iLOAD = 1'b0;
  logic [1:0]   iMODE = 2'b00;
  logic [7:0]   iDUTY = 8'd0;
  logic         iDIR = 1'b0;
  logic [N-1:0] oLED;
  logic         oTICK;

  int checks = 0;
  int passes = 0;

  int mK = 0;
  int mMode = 0;
  int mDuty = 0;
  int mPos = 0;

  led_pattern_gen #(.N_CH(N), .PRESCALE(P)) dut (
    .iCLK(clk),
    .iRST_N(rst_n),
    .iLOAD(iLOAD),
    .iMODE(iMODE),
    .iDUTY(iDUTY),
    .iDIR(iDIR),
    .oLED(oLED),
    .oTICK(oTICK)
  );

  always #5 clk = ~clk;

  // Model state is just cycles elapsed since the last restart plus the chaser position.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mK = 0; mMode = 0; mDuty = 0; mPos = 0;
    end else if (iLOAD) begin
      mMode = int'(iMODE); mDuty = int'(iDUTY); mK = 0; mPos = 0;
    end else begin
      if ((mK % P) == P - 1 && mMode == 2)
        mPos = iDIR ? (mPos + N - 1) % N : (mPos + 1) % N;
      mK++;
    end
  end

  function automatic logic [N-1:0] expLed();
    case (mMode)
      1:       return (((mK / P) % 2) == 1) ? {N{1'b1}} : {N{1'b0}};
      2:       return N'(1) << mPos;
      3:       return ((mK % 256) < mDuty) ? {N{1'b1}} : {N{1'b0}};
      default: return '0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    checkOutput("modelLed", 32'(oLED), 32'(expLed()));
    checkOutput("modelTick", 32'(oTICK), 32'((mK % P) == P - 1));
  end

  task automatic applyStimulus(input logic [1:0] mode, input logic [7:0] duty);
    @(posedge clk);
    #2 iLOAD = 1'b1; iMODE = mode; iDUTY = duty;
    @(posedge clk);
    #2 iLOAD = 1'b0;
  endtask

  initial begin
    int cnt [N];
    int found;
    logic [7:0] duties [3] = '{8'd0, 8'd64, 8'd255};
    int expHigh [3] = '{0, 128, 510};

    repeat (3) begin
      @(negedge clk);
      checkOutput("resetLed", 32'(oLED), 32'h0);
      checkOutput("resetTick", 32'(oTICK), 32'h0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("tickCycle1", 32'(oTICK), 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("tickCycle4", 32'(oTICK), 32'h1);
    @(negedge clk);
    checkOutput("tickCycle5", 32'(oTICK), 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("tickCycle8", 32'(oTICK), 32'h1);

    applyStimulus(2'b01, 8'd0);
    @(negedge clk);
    checkOutput("blinkC1", 32'(oLED), 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("blinkC4", 32'(oLED), 32'h0);
    @(negedge clk);
    checkOutput("blinkC5", 32'(oLED), 32'hF);
    repeat (3) @(negedge clk);
    checkOutput("blinkC8", 32'(oLED), 32'hF);
    @(negedge clk);
    checkOutput("blinkC9", 32'(oLED), 32'h0);

    iDIR = 1'b0;
    applyStimulus(2'b10, 8'd0);
    @(negedge clk);
    checkOutput("chase0", 32'(oLED), 32'h1);
    repeat (4) @(negedge clk);
    checkOutput("chase1", 32'(oLED), 32'h2);
    repeat (4) @(negedge clk);
    checkOutput("chase2", 32'(oLED), 32'h4);
    repeat (4) @(negedge clk);
    checkOutput("chase3", 32'(oLED), 32'h8);
    repeat (4) @(negedge clk);
    checkOutput("chaseWrap", 32'(oLED), 32'h1);
    iDIR = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("chaseDown", 32'(oLED), 32'h8);
    iDIR = 1'b0;

    for (int d = 0; d < 3; d++) begin
      applyStimulus(2'b11, duties[d]);
      for (int c = 0; c < N; c++) cnt[c] = 0;
      repeat (512) begin
        @(negedge clk);
        for (int c = 0; c < N; c++) cnt[c] += int'(oLED[c]);
      end
      for (int c = 0; c < N; c++) checkOutput("pwmHighCount", 32'(cnt[c]), 32'(expHigh[d]));
    end

    applyStimulus(2'b01, 8'd0);
    repeat (5) @(posedge clk);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(posedge clk);
      #2 if (oTICK) found = 1;
    end
    checkOutput("tickFound", 32'(found), 32'h1);
    iLOAD = 1'b1; iMODE = 2'b01;
    @(posedge clk);
    #2 iLOAD = 1'b0;
    @(negedge clk);
    checkOutput("loadOnTickLed", 32'(oLED), 32'h0);
    checkOutput("loadOnTickTick", 32'(oTICK), 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("loadOnTickNext", 32'(oTICK), 32'h1);
    checkOutput("loadOnTickHold", 32'(oLED), 32'h0);

    applyStimulus(2'b10, 8'd0);
    @(negedge clk);
    repeat (8) @(negedge clk);
    checkOutput("chasePos2", 32'(oLED), 32'h4);
    #3 rst_n = 1'b0;
    #1 checkOutput("asyncResetLed", 32'(oLED), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkOutput("offAfterReset", 32'(oLED), 32'h0);
    end

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #2;
      rst_n = ($urandom_range(0, 599) != 0);
      iDIR  = 1'($urandom);
      iLOAD = ($urandom_range(0, 59) == 0);
      iMODE = 2'($urandom);
      iDUTY = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 1) * 255) : 8'($urandom);
    end
    @(posedge clk);
    #2 rst_n = 1'b1; iLOAD = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
